chanx_pipelined_routing_channel: RTL and testbench

// Parametrised routing channel: CHAN_WIDTH tracks pass from chan_in to chan_out, each with a
// run-time configurable retiming depth of 0..PIPE_DEPTH register stages.
// The per-track depth is loaded through a serial configuration scan chain with shadow/commit.

---
 rtl/chanx_pipelined_routing_channel.sv | 98 +++++++++
 tb/tb_chanx_pipelined_routing_channel.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/chanx_pipelined_routing_channel.sv
// Routing channel: per-track retiming of 0..PIPE_DEPTH stages, depth chosen by a serial
// shadow config chain that commits on the falling edge of cfg_en.
module chanx_pipelined_routing_channel #(
    parameter int CHAN_WIDTH = 30,
    parameter int PIPE_DEPTH = 3,
    parameter int CFG_BITS   = $clog2(PIPE_DEPTH + 1),
    parameter int MID_REG    = 0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  cfg_en,
    input  logic                  cfg_in,
    output logic                  cfg_out,
    output logic                  cfg_done,
    input  logic [CHAN_WIDTH-1:0] chan_in,
    output logic [CHAN_WIDTH-1:0] chan_out,
    output logic [CHAN_WIDTH-1:0] mid_out
);

    localparam int N = CHAN_WIDTH * CFG_BITS;

    logic [N-1:0]          shadow_q, shadow_d;
    logic [N-1:0]          active_q, active_d;
    logic                  cfg_en_q, cfg_en_d;
    logic                  cfg_done_q, cfg_done_d;
    logic [CHAN_WIDTH-1:0] pipe_q [PIPE_DEPTH];
    logic [CHAN_WIDTH-1:0] pipe_d [PIPE_DEPTH];
    logic                  commit;
    logic [CFG_BITS-1:0]   track_cfg;

    always_comb begin
        commit     = cfg_en_q & ~cfg_en;
        shadow_d   = cfg_en ? ((shadow_q << 1) | N'(cfg_in)) : shadow_q;
        active_d   = commit ? shadow_q : active_q;
        cfg_en_d   = cfg_en;
        cfg_done_d = commit;
        // Stages always shift; a commit flushes them so stale data never appears at a new tap.
        pipe_d[0]  = commit ? '0 : chan_in;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            pipe_d[k] = commit ? '0 : pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            shadow_q   <= '0;
            active_q   <= '0;
            cfg_en_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            cfg_en_q   <= cfg_en_d;
            cfg_done_q <= cfg_done_d;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    // Highest stage not exceeding the field wins, which also clamps oversize fields.
    always_comb begin
        chan_out  = chan_in;
        track_cfg = '0;
        for (int i = 0; i < CHAN_WIDTH; i++) begin
            track_cfg = active_q[i*CFG_BITS +: CFG_BITS];
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                if (int'(track_cfg) >= k) begin
                    chan_out[i] = pipe_q[k-1][i];
                end
            end
        end
    end

    assign cfg_out  = shadow_q[N-1];
    assign cfg_done = cfg_done_q;

    generate
        if (MID_REG != 0) begin : g_mid_reg
            logic [CHAN_WIDTH-1:0] mid_q, mid_d;
            always_comb mid_d = chan_in;
            always_ff @(posedge clk) begin
                if (!Reset) begin
                    mid_q <= '0;
                end else begin
                    mid_q <= mid_d;
                end
            end
            assign mid_out = mid_q;
        end else begin : g_mid_comb
            assign mid_out = chan_in;
        end
    endgenerate

endmodule

// File: tb/tb_chanx_pipelined_routing_channel.sv
// Bench for the routing channel: two instances (depth 3 / combinational mid, depth 2 /
// registered mid) share stimulus and are checked against a cycle model through a queue.
module tb_chanx_pipelined_routing_channel;

    localparam int CW = 30;
    localparam int NB = 60;

    logic          clk;
    logic          Reset;
    logic          cfg_en;
    logic          cfg_in;
    logic [CW-1:0] chan_in;
    logic          cfg_out, cfg_done, cfg_out2, cfg_done2;
    logic [CW-1:0] chan_out, mid_out, chan_out2, mid_out2;

    chanx_pipelined_routing_channel #(.CHAN_WIDTH(CW), .PIPE_DEPTH(3), .MID_REG(0)) u_dut (
        .clk(clk), .Reset(Reset), .cfg_en(cfg_en), .cfg_in(cfg_in),
        .cfg_out(cfg_out), .cfg_done(cfg_done),
        .chan_in(chan_in), .chan_out(chan_out), .mid_out(mid_out)
    );

    chanx_pipelined_routing_channel #(.CHAN_WIDTH(CW), .PIPE_DEPTH(2), .MID_REG(1)) u_dut2 (
        .clk(clk), .Reset(Reset), .cfg_en(cfg_en), .cfg_in(cfg_in),
        .cfg_out(cfg_out2), .cfg_done(cfg_done2),
        .chan_in(chan_in), .chan_out(chan_out2), .mid_out(mid_out2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_q[$];

    // Reference model state
    logic [NB-1:0] m_shadow = '0;
    logic [NB-1:0] m_active = '0;
    logic          m_en_q = 1'b0;
    logic          m_done = 1'b0;
    logic [CW-1:0] m_mid2 = '0;
    logic [CW-1:0] m_hist[$];
    int            m_since = 0;
    bit            m_valid = 1'b0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_out(input logic [CW-1:0] din, input int max_d);
        logic [CW-1:0] r;
        int d;
        r = '0;
        for (int i = 0; i < CW; i++) begin
            d = int'(m_active[i*2 +: 2]);
            if (d > max_d) d = max_d;
            if (d == 0) r[i] = din[i];
            else if (m_since >= d && m_hist.size() >= d) r[i] = m_hist[d-1][i];
            else r[i] = 1'b0;
        end
        return r;
    endfunction

    // One clock: drive at negedge, check mid-phase, then advance the model past the posedge.
    task automatic cycle(input logic [CW-1:0] din, input logic en, input logic bi, input logic rst);
        logic commit;
        @(negedge clk);
        Reset   = rst;
        cfg_en  = en;
        cfg_in  = bi;
        chan_in = din;
        if (m_valid) begin
            exp_q.push_back(model_out(din, 3));
            exp_q.push_back(model_out(din, 2));
        end
        #2;
        if (m_valid) begin
            chk("chan_out", chan_out, exp_q.pop_front());
            chk("chan_out2", chan_out2, exp_q.pop_front());
            chk("mid_out", mid_out, din);
            chk("mid_out2", mid_out2, m_mid2);
            chk("cfg_out", CW'(cfg_out), CW'(m_shadow[NB-1]));
            chk("cfg_done", CW'(cfg_done), CW'(m_done));
            chk("cfg_done2", CW'(cfg_done2), CW'(m_done));
        end
        commit = m_en_q & ~en;
        if (!rst) begin
            m_shadow = '0;
            m_active = '0;
            m_en_q   = 1'b0;
            m_done   = 1'b0;
            m_mid2   = '0;
            m_since  = 0;
            m_hist.delete();
            m_valid  = 1'b1;
        end else begin
            if (commit) begin
                m_active = m_shadow;
                m_since  = 0;
            end else begin
                m_since++;
            end
            m_hist.push_front(din);
            if (m_hist.size() > 4) void'(m_hist.pop_back());
            if (en) m_shadow = {m_shadow[NB-2:0], bi};
            m_en_q = en;
            m_done = commit;
            m_mid2 = din;
        end
    endtask

    task automatic load_cfg(input logic [NB-1:0] cfg);
        for (int b = NB - 1; b >= 0; b--) begin
            cycle(CW'($urandom()), 1'b1, cfg[b], 1'b1);
        end
        cycle(CW'($urandom()), 1'b0, 1'b0, 1'b1);
    endtask

    logic [NB-1:0] cfg;

    initial begin
        Reset   = 1'b0;
        cfg_en  = 1'b0;
        cfg_in  = 1'b0;
        chan_in = '0;

        // Reset with a fixed pattern: bypass, cfg_out and cfg_done low.
        cycle(30'h2AAAAAAA, 1'b0, 1'b0, 1'b0);
        cycle(30'h2AAAAAAA, 1'b0, 1'b0, 1'b0);
        cycle(30'h2AAAAAAA, 1'b0, 1'b0, 1'b1);
        cycle(30'h15555555, 1'b0, 1'b0, 1'b1);

        // All tracks depth 2, single one pulse after commit.
        for (int i = 0; i < CW; i++) cfg[i*2 +: 2] = 2'd2;
        load_cfg(cfg);
        cycle(30'h1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) cycle('0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) cycle(CW'($urandom()), 1'b0, 1'b0, 1'b1);

        // Mixed depths with a walking one.
        for (int i = 0; i < CW; i++) cfg[i*2 +: 2] = 2'd1;
        cfg[1:0] = 2'd0;
        cfg[3:2] = 2'd3;
        load_cfg(cfg);
        for (int c = 0; c < CW + 4; c++) cycle((c < CW) ? (30'h1 << c) : 30'h0, 1'b0, 1'b0, 1'b1);

        // Long shift of a random config: old depths hold, cfg_out replays old bits.
        for (int i = 0; i < NB; i++) cfg[i] = 1'($urandom_range(0, 1));
        load_cfg(cfg);
        for (int c = 0; c < 12; c++) cycle(CW'($urandom()), 1'b0, 1'b0, 1'b1);

        // Clamp: track 5 field 3 -> depth 3 on first instance, depth 2 on second.
        cfg = '0;
        cfg[11:10] = 2'b11;
        load_cfg(cfg);
        for (int c = 0; c < 10; c++) cycle(CW'($urandom_range(0, 1)) << 5, 1'b0, 1'b0, 1'b1);

        // Back-to-back one-cycle cfg_en pulses.
        for (int c = 0; c < 4; c++) begin
            cycle(CW'($urandom()), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            cycle(CW'($urandom()), 1'b0, 1'b0, 1'b1);
        end
        for (int c = 0; c < 5; c++) cycle(CW'($urandom()), 1'b0, 1'b0, 1'b1);

        // Reset after 20 shifted bits: no commit, shadow and depths cleared.
        for (int c = 0; c < 20; c++) cycle(CW'($urandom()), 1'b1, 1'b1, 1'b1);
        cycle(CW'($urandom()), 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) cycle(CW'($urandom()), 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) cycle(CW'($urandom()), 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) cycle(CW'($urandom()), 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
